// File: rtl/pe_arbiter_if.sv
// Request/grant bundle shared by the requesters and pe_arbiter.
interface pe_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/pe_arbiter.sv
// 8-way grant arbiter with hold limit and a dead cycle between grants.
// Define PE_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed (bit 7 highest).
module pe_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [2:0] winner;
  logic       owner_req;
  logic       limit_hit;
  logic       release_now;

`ifdef PE_ARB_ROUND_ROBIN_EN
  logic [2:0] ptr;
  logic [2:0] idx;

  // Scan from ptr (lowest priority) upward; the last hit, ptr-1, has highest priority.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (arb.req[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd7;
    end else if (state == BUSY && release_now) begin
      ptr <= arb.gnt_id;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (arb.req[i]) winner = 3'(i);
    end
  end
`endif

  assign owner_req   = arb.req[arb.gnt_id];
  assign limit_hit   = (hold_cnt == HOLD_LAST);
  assign release_now = arb.done | ~owner_req | limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      arb.gnt       <= '0;
      arb.gnt_id    <= '0;
      arb.gnt_valid <= 1'b0;
      arb.timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          arb.timeout <= 1'b0;
          if (|arb.req) begin
            state         <= BUSY;
            hold_cnt      <= '0;
            arb.gnt       <= 8'b1 << winner;
            arb.gnt_id    <= winner;
            arb.gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (release_now) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            arb.gnt       <= '0;
            arb.gnt_id    <= '0;
            arb.gnt_valid <= 1'b0;
            arb.timeout   <= limit_hit & ~arb.done & owner_req;
          end else begin
            arb.timeout <= 1'b0;
            if (hold_cnt != '1) hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_arbiter.sv
// Scoreboard bench for pe_arbiter: a cycle-level grant model feeds an expectation queue.
module tb_pe_arbiter;
  localparam int MAX_HOLD = 16;

  logic clk;
  logic rst_n;

  pe_arbiter_if bus();

  pe_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: owner index (-1 when idle), cycles the grant has been visible, last released owner.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r);
`ifdef PE_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = ((m_ptr - k) % 8 + 8) % 8;
      if (r[j]) return j;
    end
`else
    for (int k = 7; k >= 0; k--) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic push_expect(input bit to);
    exp_t e;
    e.gnt   = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.id    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.valid = (m_owner >= 0);
    e.to    = to;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit to;
    bit lim;
    int w;
    to = 1'b0;
    if (m_owner < 0) begin
      w = pick(r);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end else begin
      lim = (m_held == MAX_HOLD);
      if (d || !r[m_owner] || lim) begin
        to      = lim && !d && r[m_owner];
        m_ptr   = m_owner;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
      end
    end
    push_expect(to);
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: gnt=%h id=%0d valid=%b timeout=%b, required all zero",
               name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout);
    end
  endtask

  // Reset-held cycle; on the asserting edge the outputs must clear without waiting for clk.
  task automatic rstep();
    bit was_running;
    @(negedge clk);
    was_running = rst_n;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    if (was_running) begin
      #1;
      check_zero("async_reset");
    end
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 7;
    push_expect(1'b0);
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gnt !== e.gnt || bus.gnt_id !== e.id || bus.gnt_valid !== e.valid || bus.timeout !== e.to) begin
          n_fail++;
          $display("FAIL cycle@%0t: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
                   $time, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, e.gnt, e.id, e.valid, e.to);
        end
      end
    end
  end

  initial begin
    logic [7:0] cur_req;
    bus.req  = '0;
    bus.done = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("reset_state");

    rstep();
    rstep();

    // Quiet bus, with done toggled to show it is ignored in IDLE.
    repeat (5) step(8'h00, 1'b0);
    step(8'h00, 1'b1);

    // Two requesters, release by done.
    step(8'h22, 1'b0);
    step(8'h22, 1'b0);
    step(8'h22, 1'b1);
    step(8'h00, 1'b0);

    // Held request runs into the hold limit.
    repeat (MAX_HOLD + 4) step(8'h02, 1'b0);
    step(8'h00, 1'b0);

    // done arrives on the same edge as the hold limit.
    step(8'h10, 1'b0);
    for (int n = 0; n < 3 * MAX_HOLD && m_held != MAX_HOLD; n++) step(8'h10, 1'b0);
    step(8'h10, 1'b1);
    step(8'h00, 1'b0);

    // Losing requester drops while another holds the grant.
    step(8'h81, 1'b0);
    step(8'h80, 1'b0);
    step(8'h81, 1'b0);
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);

    // All requesters busy, each grant released by done.
    repeat (10) begin
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end
    step(8'h00, 1'b0);

    // Reset dropped in the middle of a grant to requester 3.
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    rstep();
    rstep();
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    step(8'h00, 1'b0);

    // Random traffic: requests change occasionally, done is sparse.
    cur_req = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) cur_req = 8'($urandom()) & 8'($urandom());
      step(cur_req, ($urandom_range(0, 7) == 0));
    end
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_arbiter.md
PE_ARBITER -- requirements
Module: pe_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum number of cycles one grant may be held before forced release (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  8  request vector; bit i high means requester i wants the shared resource.
REQ-005 Port: done  input  1  granted requester finished; releases the grant.
REQ-006 Port: gnt  output  8  one-hot grant vector; all zeros when no grant is active.
REQ-007 Port: gnt_id  output  3  binary index of the granted requester; 3'b000 when gnt_valid=0.
REQ-008 Port: gnt_valid  output  1  high while a grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is force-released by the MAX_HOLD limit.

Function
REQ-010 FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant active).
REQ-011 All outputs SHALL be registered, with no combinational path from req or done to any output.
REQ-012 In IDLE with req != 0 at a clock edge, the next cycle SHALL enter BUSY with gnt one-hot on the winner, gnt_id = winner index, gnt_valid = 1 and hold counter = 0.
REQ-013 In IDLE with req == 0, state SHALL remain IDLE and outputs SHALL remain zero; done SHALL be ignored in IDLE.
REQ-014 Winner selection SHALL be a priority encode of req relative to the priority pointer (see Configuration); the encoding is never ambiguous and exactly one bit is granted.
REQ-015 In BUSY, the hold counter SHALL increment by 1 every cycle and SHALL saturate, never wrapping.
REQ-016 Release from BUSY SHALL occur when done=1, or req[gnt_id]=0, or hold counter == MAX_HOLD-1.
REQ-017 On release, the next cycle SHALL be IDLE with gnt=0, gnt_id=0 and gnt_valid=0; a dead cycle always separates two grants, even when requests are pending.
REQ-018 timeout SHALL pulse for exactly one cycle, aligned with the first IDLE cycle, only when release is caused solely by the counter limit.
REQ-019 If done=1 and the counter limit coincide on the same edge, release SHALL occur and timeout SHALL stay 0.
REQ-020 Changes on req bits other than the granted bit during BUSY SHALL have no effect on gnt.
REQ-021 Grant latency from the first req assertion in IDLE SHALL be 1 cycle; worst-case grant occupancy SHALL be MAX_HOLD cycles.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately (asynchronously) force state to IDLE, with gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0 and priority pointer=7.
REQ-023 Reset asserted mid-grant SHALL drop the grant without producing a timeout pulse.
REQ-024 After rst_n deassertion, the first grant SHALL be possible on the second rising edge.

Configuration
REQ-025 Macro PE_ARB_ROUND_ROBIN_EN SHALL select the round-robin priority scheme when defined.
REQ-026 When the macro is defined, the requester search SHALL start from index pointer-1 and descend modulo 8; on each release the pointer SHALL load gnt_id of the released grant, so that requester becomes lowest priority.
REQ-027 When the macro is undefined, priority SHALL be fixed with bit 7 highest and bit 0 lowest; the pointer register SHALL be absent.

Verification
REQ-028 Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
REQ-029 req=8'b0010_0010 in IDLE -> next cycle gnt=8'b0010_0000, gnt_id=3'b101, gnt_valid=1; assert done -> next cycle gnt=0.
REQ-030 Same request held (req=8'h02), MAX_HOLD=16, done=0 -> gnt held 16 cycles, then gnt=0 with timeout=1 for one cycle.
REQ-031 With PE_ARB_ROUND_ROBIN_EN defined and req=8'hFF constant, each grant released by done -> gnt_id sequence 7,6,5,4,3,2,1,0,7; with the macro undefined -> gnt_id is always 7.
REQ-032 rst_n pulled low mid-grant (gnt_id=3) -> gnt=0 immediately, timeout=0, and the next grant follows fixed/reset pointer order.
REQ-033 done=1 on the same edge as the counter limit -> release occurs with timeout=0.
